// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared instruction/data memory: CPU datapath (port 0) and I/O loader (port 1).
// Round-robin on contention, fixed wait states per access, one-cycle ack to the winner.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate among pending requests
// ACCESS | mem_en held for WAIT_CYCLES cycles with latched fields
// RESP   | pulse grantee's ack for one cycle, then back to IDLE
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
    logic              grant_io;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;
        grant_io    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || io_req) begin
                    // On contention the port that did not win last time goes first.
                    grant_io = io_req && (!cpu_req || !owner_q);
                    owner_d  = grant_io;
                    we_d     = grant_io ? io_we    : cpu_we;
                    addr_d   = grant_io ? io_addr  : cpu_addr;
                    wdata_d  = grant_io ? io_wdata : cpu_wdata;
                    cnt_d    = CNT_LOAD;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) io_rdata_d  = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == RESP) && !owner_q;
    assign io_ack    = (state_q == RESP) && owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign io_rdata  = io_rdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then randomized two-port traffic against a transaction-level timing/memory model.
module tb_mem_arbiter;
    parameter int WAIT = 2;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, io_req, io_we;
    logic [AW-1:0] cpu_addr, io_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, io_wdata, cpu_rdata, io_rdata, mem_wdata, mem_rdata;
    logic          cpu_ack, io_ack, mem_en, mem_we, busy, owner;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    // Memory device: data only valid on the last enabled cycle, garbage otherwise.
    logic [DW-1:0] mem_arr [0:255];
    logic          mem_reinit;
    int            en_run = 0;

    function automatic logic [15:0] init_val(int i);
        return {8'hC0, 8'(i)};
    endfunction

    always @(posedge clock) begin
        if (mem_reinit) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
        end
        en_run <= mem_en ? en_run + 1 : 0;
    end

    assign mem_rdata = (mem_en && en_run == WAIT - 1) ? mem_arr[mem_addr[7:0]] : 16'hDEAD;

    int passes = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        io_req  = 0; io_we  = 0; io_addr  = '0; io_wdata  = '0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1;
        idle_inputs();
        @(negedge clock);
        reset = 0;
    endtask

    task automatic single(input bit io, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp, input string nm);
        int k, en_cnt;
        bit got, other;
        @(negedge clock);
        if (io) begin io_req = 1; io_we = we; io_addr = addr; io_wdata = wd; end
        else    begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        k = 0; en_cnt = 0; got = 0; other = 0;
        while (!got && k < 30) begin
            @(negedge clock);
            k++;
            if (mem_en) begin
                en_cnt++;
                chk({nm, " mem_addr"}, mem_addr, addr);
                chk({nm, " mem_we"}, mem_we, we);
                if (we) chk({nm, " mem_wdata"}, mem_wdata, wd);
            end
            if (io ? cpu_ack : io_ack) other = 1;
            if (io ? io_ack : cpu_ack) got = 1;
        end
        chk({nm, " acked"}, got, 1);
        chk({nm, " latency"}, k, WAIT + 1);
        chk({nm, " en_cycles"}, en_cnt, WAIT);
        chk({nm, " other_ack"}, other, 0);
        chk({nm, " owner"}, owner, io);
        if (!we) chk({nm, " rdata"}, io ? io_rdata : cpu_rdata, exp);
        @(negedge clock);
        cpu_req = 0; io_req = 0;
    endtask

    typedef struct {
        bit          io;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [9];

    // Reference model state for the random phase.
    logic [15:0] mm [0:255];
    logic [15:0] er [2];
    logic [15:0] caddr, cwd, crd;
    bit          have, cw, cwho, last_who, who;
    int          g, a, free_at;
    bit          pend [2], dropn [2], grnt [2];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[1] = '{0, 0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[2] = '{1, 1, 16'h0020, 16'h1234, 16'h0000};
        vecs[3] = '{0, 0, 16'h0020, 16'h0000, 16'h1234};
        vecs[4] = '{1, 0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[5] = '{1, 0, 16'h0003, 16'h0000, 16'hC003};
        vecs[6] = '{0, 1, 16'h00FF, 16'h0000, 16'h0000};
        vecs[7] = '{1, 0, 16'h00FF, 16'h5555, 16'h0000};
        vecs[8] = '{0, 0, 16'h0004, 16'h0000, 16'hC004};

        idle_inputs();
        reset = 1;
        mem_reinit = 1;
        repeat (3) @(negedge clock);
        mem_reinit = 0;
        chk("rst mem_en", mem_en, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst busy", busy, 0);
        chk("rst cpu_ack", cpu_ack, 0);
        chk("rst io_ack", io_ack, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst cpu_rdata", cpu_rdata, 0);
        chk("rst io_rdata", io_rdata, 0);
        chk("rst owner", owner, 1);
        reset = 0;

        foreach (vecs[i])
            single(vecs[i].io, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
                   $sformatf("vec%0d", i));

        // Contention after reset: both held, CPU first then alternating.
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        io_req  = 1; io_we  = 0; io_addr  = 16'h0020;
        for (int k = 1; k <= 4 * WAIT + 7; k++) begin
            @(negedge clock);
            chk($sformatf("cont cpu_ack k%0d", k), cpu_ack,
                (k == WAIT + 1) || (k == 3 * WAIT + 5));
            chk($sformatf("cont io_ack k%0d", k), io_ack,
                (k == 2 * WAIT + 3) || (k == 4 * WAIT + 7));
            if (k == WAIT + 1 || k == 3 * WAIT + 5) begin
                chk("cont cpu_rdata", cpu_rdata, 16'hBEEF);
                chk("cont owner cpu", owner, 0);
            end
            if (k == 2 * WAIT + 3 || k == 4 * WAIT + 7) begin
                chk("cont io_rdata", io_rdata, 16'h1234);
                chk("cont owner io", owner, 1);
            end
        end
        @(negedge clock);
        idle_inputs();
        @(negedge clock);

        // Field stability: address changed during ACCESS must not reach the bus.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        for (int k = 1; k <= WAIT + 1; k++) begin
            @(negedge clock);
            if (k == 1) cpu_addr = 16'h00FF;
            if (k <= WAIT) begin
                chk("stab mem_en", mem_en, 1);
                chk("stab mem_addr", mem_addr, 16'h0010);
            end
        end
        chk("stab cpu_ack", cpu_ack, 1);
        chk("stab cpu_rdata", cpu_rdata, 16'hBEEF);
        chk("stab owner", owner, 0);
        @(negedge clock);
        idle_inputs();
        @(negedge clock);

        // Reset during first ACCESS cycle abandons the read.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        @(negedge clock);
        chk("rstmid in_access", mem_en, 1);
        reset = 1;
        cpu_req = 0;
        @(negedge clock);
        chk("rstmid mem_en", mem_en, 0);
        chk("rstmid busy", busy, 0);
        chk("rstmid cpu_ack", cpu_ack, 0);
        chk("rstmid cpu_rdata", cpu_rdata, 0);
        chk("rstmid owner", owner, 1);
        chk("rstmid mem_addr", mem_addr, 0);
        reset = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("rstmid no_ack", cpu_ack, 0);
            chk("rstmid rdata_held", cpu_rdata, 0);
        end

        // Randomized traffic against the transaction-level model.
        @(negedge clock);
        reset = 1; mem_reinit = 1;
        idle_inputs();
        @(negedge clock);
        reset = 0; mem_reinit = 0;
        for (int i = 0; i < 256; i++) mm[i] = init_val(i);
        er[0] = '0; er[1] = '0;
        have = 0; last_who = 1; free_at = 0; g = 0; a = 0;
        cw = 0; cwho = 0; caddr = '0; cwd = '0; crd = '0;
        for (int p = 0; p < 2; p++) begin pend[p] = 0; dropn[p] = 0; grnt[p] = 0; end

        for (int c = 0; c < 3000; c++) begin
            bit en_e, busy_e, cack_e, iack_e;
            if (c > 0) @(negedge clock);
            en_e   = have && c >= g && c < g + WAIT;
            busy_e = have && c >= g && c <= a;
            cack_e = have && c == a && cwho == 0;
            iack_e = have && c == a && cwho == 1;
            if (have && c == a && !cw) er[cwho] = crd;
            chk("rnd mem_en", mem_en, en_e);
            chk("rnd mem_we", mem_we, en_e && cw);
            chk("rnd busy", busy, busy_e);
            chk("rnd cpu_ack", cpu_ack, cack_e);
            chk("rnd io_ack", io_ack, iack_e);
            chk("rnd owner", owner, last_who);
            chk("rnd cpu_rdata", cpu_rdata, er[0]);
            chk("rnd io_rdata", io_rdata, er[1]);
            if (en_e) begin
                chk("rnd mem_addr", mem_addr, caddr);
                if (cw) chk("rnd mem_wdata", mem_wdata, cwd);
            end

            for (int p = 0; p < 2; p++) begin
                bit ackp;
                ackp = p ? io_ack : cpu_ack;
                if (dropn[p]) begin
                    if (p) io_req = 0; else cpu_req = 0;
                    dropn[p] = 0; pend[p] = 0; grnt[p] = 0;
                end else if (ackp) begin
                    dropn[p] = 1;
                end else if (!pend[p]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pend[p] = 1;
                        if (p) begin
                            io_req = 1; io_we = 1'($urandom);
                            io_addr = 16'($urandom_range(0, 15)); io_wdata = 16'($urandom);
                        end else begin
                            cpu_req = 1; cpu_we = 1'($urandom);
                            cpu_addr = 16'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
                        end
                    end
                end else if (grnt[p]) begin
                    if (p) begin
                        io_we = 1'($urandom); io_addr = 16'($urandom); io_wdata = 16'($urandom);
                        if ($urandom_range(0, 7) == 0) io_req = 0;
                    end else begin
                        cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
                        if ($urandom_range(0, 7) == 0) cpu_req = 0;
                    end
                end
            end

            if (c + 1 >= free_at && (cpu_req || io_req)) begin
                who = (cpu_req && io_req) ? !last_who : io_req;
                cwho  = who;
                cw    = who ? io_we : cpu_we;
                caddr = who ? io_addr : cpu_addr;
                cwd   = who ? io_wdata : cpu_wdata;
                have = 1; g = c + 1; a = c + 1 + WAIT; free_at = c + 1 + WAIT + 2;
                last_who = who;
                if (cw) mm[caddr[7:0]] = cwd;
                else    crd = mm[caddr[7:0]];
                grnt[who] = 1;
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
